// File: rtl/ife_bypass_arbiter.sv
// ife_bypass_arbiter
//   Shares the single IFE bypass path between the dispatch and commit
//   fallback requesters. One block is accepted per cycle into a registered
//   output stage. Commit has fixed priority, and a starvation counter forces
//   a dispatch grant after MAX_STARVE consecutive lost arbitrations.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   flush                             drop held entry, clear starvation state
//   disp_valid/ready/block_id/block   dispatch request handshake + payload
//   cmt_valid/ready/block_id/block    commit request handshake + payload
//   out_valid/ready/block_id/block    registered output toward bypass path
//   out_from_dispatch/out_from_commit one-hot source tag of the held entry
//   xfer_count                        saturating count of delivered blocks
module ife_bypass_arbiter #(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE     = 4,
  parameter int unsigned MAX_STARVE     = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                disp_valid,
  output logic                                disp_ready,
  input  logic [BLOCK_ID_WIDTH-1:0]           disp_block_id,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   disp_block,
  input  logic                                cmt_valid,
  output logic                                cmt_ready,
  input  logic [BLOCK_ID_WIDTH-1:0]           cmt_block_id,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   cmt_block,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BLOCK_ID_WIDTH-1:0]           out_block_id,
  output logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   out_block,
  output logic                                out_from_dispatch,
  output logic                                out_from_commit,
  output logic [CNT_WIDTH-1:0]                xfer_count
);

  localparam int unsigned BLK_W    = BLOCK_SIZE * INSTR_WIDTH;
  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve;
  logic                load_en;
  logic                grant_disp;
  logic                grant_cmt;
  logic                accept;
  logic                drain;

  // Output stage can take a new entry when empty or draining this cycle.
  assign load_en = !rst && !flush && (!out_valid || out_ready);
  assign drain   = out_valid && out_ready;

  // Grant: forced dispatch when starved, else commit priority.
  always_comb begin
    grant_disp = 1'b0;
    grant_cmt  = 1'b0;
    if (disp_valid && (starve == STARVE_MAX)) begin
      grant_disp = 1'b1;
    end else if (cmt_valid) begin
      grant_cmt = 1'b1;
    end else if (disp_valid) begin
      grant_disp = 1'b1;
    end
  end

  assign disp_ready = load_en && grant_disp;
  assign cmt_ready  = load_en && grant_cmt;
  assign accept     = disp_ready || cmt_ready;

  // Registered output stage; data and tags hold after a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_block_id      <= '0;
      out_block         <= '0;
      out_from_dispatch <= 1'b0;
      out_from_commit   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_block_id      <= disp_ready ? disp_block_id : cmt_block_id;
      out_block         <= disp_ready ? disp_block : cmt_block;
      out_from_dispatch <= disp_ready;
      out_from_commit   <= cmt_ready;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Starvation counter: counts dispatch losses to commit, holds when stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      starve <= '0;
    end else if (disp_ready) begin
      starve <= '0;
    end else if (disp_valid && cmt_ready && (starve != STARVE_MAX)) begin
      starve <= starve + STARVE_W'(1);
    end
  end

  // Delivered-block counter; a drain in the flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (drain && (xfer_count != {CNT_WIDTH{1'b1}})) begin
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

  logic unused_blk_w;
  assign unused_blk_w = (BLK_W == 0);

endmodule

// File: tb/tb_ife_bypass_arbiter.sv
// Directed self-checking bench for ife_bypass_arbiter. A second instance
// with a 4-bit transfer counter shares the stimulus to check saturation.
module tb_ife_bypass_arbiter;

  localparam int unsigned IDW = 8;
  localparam int unsigned BW  = 128;

  logic           clk = 1'b0;
  logic           rst, flush;
  logic           disp_valid, disp_ready, cmt_valid, cmt_ready;
  logic [IDW-1:0] disp_block_id, cmt_block_id, out_block_id;
  logic [BW-1:0]  disp_block, cmt_block, out_block;
  logic           out_valid, out_ready, out_from_dispatch, out_from_commit;
  logic [15:0]    xfer_count;

  logic           s_disp_ready, s_cmt_ready, s_out_valid, s_fd, s_fc;
  logic [IDW-1:0] s_out_block_id;
  logic [BW-1:0]  s_out_block;
  logic [3:0]     s_xfer_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ife_bypass_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_block_id(disp_block_id), .disp_block(disp_block),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .cmt_block_id(cmt_block_id), .cmt_block(cmt_block),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block_id(out_block_id), .out_block(out_block),
    .out_from_dispatch(out_from_dispatch), .out_from_commit(out_from_commit),
    .xfer_count(xfer_count)
  );

  ife_bypass_arbiter #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(s_disp_ready),
    .disp_block_id(disp_block_id), .disp_block(disp_block),
    .cmt_valid(cmt_valid), .cmt_ready(s_cmt_ready),
    .cmt_block_id(cmt_block_id), .cmt_block(cmt_block),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_block_id(s_out_block_id), .out_block(s_out_block),
    .out_from_dispatch(s_fd), .out_from_commit(s_fc),
    .xfer_count(s_xfer_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [BW-1:0] blk_a;
  logic [15:0]   xb;
  logic          prev_d;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    disp_valid = 1'b0; disp_block_id = '0; disp_block = '0;
    cmt_valid = 1'b0;  cmt_block_id = '0;  cmt_block = '0;
    tick(); tick();
    #1;
    check("rst_disp_ready", 128'(disp_ready), 128'd0);
    check("rst_cmt_ready", 128'(cmt_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_id", 128'(out_block_id), 128'd0);
    check("rst_out_block", out_block, 128'd0);
    check("rst_tags", 128'({out_from_dispatch, out_from_commit}), 128'd0);
    check("rst_starve", 128'(dut.starve), 128'd0);
    check("rst_xfer", 128'(xfer_count), 128'd0);

    // Idle for 10 cycles
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("idle_out_valid", 128'(out_valid), 128'd0);
    check("idle_xfer", 128'(xfer_count), 128'd0);

    // Single dispatch
    tick();
    blk_a = {32'h6F, 32'h93, 32'h33, 32'h13};
    disp_valid = 1'b1; disp_block_id = 8'h2A; disp_block = blk_a;
    #1;
    check("single_disp_ready", 128'(disp_ready), 128'd1);
    check("single_cmt_ready", 128'(cmt_ready), 128'd0);
    tick();
    disp_valid = 1'b0;
    #1;
    check("single_out_valid", 128'(out_valid), 128'd1);
    check("single_out_id", 128'(out_block_id), 128'h2A);
    check("single_out_block", out_block, blk_a);
    check("single_tags", 128'({out_from_dispatch, out_from_commit}), 128'b10);
    check("single_xfer_pre", 128'(xfer_count), 128'd0);
    tick();
    #1;
    check("single_xfer_post", 128'(xfer_count), 128'd1);
    check("single_drained", 128'(out_valid), 128'd0);

    // Both valid: C,C,C,C,D repeating
    xb = xfer_count;
    prev_d = 1'b0;
    tick();
    disp_valid = 1'b1; disp_block_id = 8'hD0; disp_block = 128'hD;
    cmt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmt_block_id = 8'(8'hC0 + i); cmt_block = 128'(i);
      #1;
      check($sformatf("rr_disp_ready_%0d", i), 128'(disp_ready), 128'((i % 5) == 4));
      check($sformatf("rr_cmt_ready_%0d", i), 128'(cmt_ready), 128'((i % 5) != 4));
      if ((i % 5) == 4) check($sformatf("rr_starve_%0d", i), 128'(dut.starve), 128'd4);
      check($sformatf("rr_xfer_%0d", i), 128'(xfer_count), 128'(xb + 16'((i > 0) ? i - 1 : 0)));
      if (i > 0) begin
        check($sformatf("rr_out_valid_%0d", i), 128'(out_valid), 128'd1);
        check($sformatf("rr_tag_%0d", i), 128'(out_from_dispatch), 128'(prev_d));
      end
      prev_d = ((i % 5) == 4);
      tick();
    end
    disp_valid = 1'b0; cmt_valid = 1'b0;
    #1;
    check("rr_xfer_9", 128'(xfer_count), 128'(xb + 16'd9));
    check("rr_last_tag", 128'(out_from_dispatch), 128'd1);
    tick();
    #1;
    check("rr_xfer_10", 128'(xfer_count), 128'(xb + 16'd10));
    check("rr_starve_end", 128'(dut.starve), 128'd0);

    // Backpressure
    cmt_valid = 1'b1; cmt_block_id = 8'h05; cmt_block = 128'h55;
    #1;
    check("bp_cmt_ready", 128'(cmt_ready), 128'd1);
    tick();
    cmt_valid = 1'b0; out_ready = 1'b0;
    disp_valid = 1'b1; disp_block_id = 8'h77; disp_block = 128'h77;
    xb = xfer_count;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_hold_id_%0d", i), 128'(out_block_id), 128'h05);
      check($sformatf("bp_hold_tag_%0d", i), 128'({out_valid, out_from_dispatch, out_from_commit}), 128'b101);
      check($sformatf("bp_disp_ready_%0d", i), 128'(disp_ready), 128'd0);
      check($sformatf("bp_starve_%0d", i), 128'(dut.starve), 128'd0);
      tick();
    end
    check("bp_xfer_hold", 128'(xfer_count), 128'(xb));
    out_ready = 1'b1;
    #1;
    check("bp_release_disp_ready", 128'(disp_ready), 128'd1);
    tick();
    disp_valid = 1'b0;
    #1;
    check("bp_next_id", 128'(out_block_id), 128'h77);
    check("bp_next_tag", 128'({out_valid, out_from_dispatch, out_from_commit}), 128'b110);
    check("bp_xfer", 128'(xfer_count), 128'(xb + 16'd1));
    tick();

    // Flush mid-hold with starve = 3
    disp_valid = 1'b1; cmt_valid = 1'b1; cmt_block_id = 8'h31;
    for (int i = 0; i < 3; i++) tick();
    cmt_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("fl_starve_pre", 128'(dut.starve), 128'd3);
    tick();
    #1;
    check("fl_out_valid_pre", 128'(out_valid), 128'd1);
    check("fl_starve_hold", 128'(dut.starve), 128'd3);
    xb = xfer_count;
    flush = 1'b1;
    #1;
    check("fl_disp_ready", 128'(disp_ready), 128'd0);
    check("fl_cmt_ready", 128'(cmt_ready), 128'd0);
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    #1;
    check("fl_out_valid", 128'(out_valid), 128'd0);
    check("fl_starve", 128'(dut.starve), 128'd0);
    check("fl_xfer", 128'(xfer_count), 128'(xb));
    out_ready = 1'b1;

    // Saturation on the 4-bit counter instance
    rst = 1'b1; cmt_valid = 1'b1; cmt_block_id = 8'h11;
    #1;
    check("sat_rst_cmt_ready", 128'(cmt_ready), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("sat_xfer_start", 128'(s_xfer_count), 128'd0);
    for (int i = 0; i < 20; i++) tick();
    cmt_valid = 1'b0;
    tick(); tick();
    #1;
    check("sat_main_xfer", 128'(xfer_count), 128'd20);
    check("sat_small_xfer", 128'(s_xfer_count), 128'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("sat_rst_clear", 128'(s_xfer_count), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ife_bypass_arbiter.md
# ife_bypass_arbiter

Shares the single IFE bypass path between the two fallback requesters, dispatch and commit, and sequences blocks into it one per cycle through a registered output stage. Commit has fixed priority. Dispatch is protected by a starvation counter that forces a dispatch grant after a bounded wait. The registered output carries the source tags (`from_dispatch` / `from_commit`) that the bypass path turns into its fallback indication. A saturating transfer counter is provided for performance monitoring.

## Interface
- `BLOCK_ID_WIDTH`, 8, width of block identifier
- `INSTR_WIDTH`, 32, width of one instruction
- `BLOCK_SIZE`, 4, instructions per block
- `MAX_STARVE`, 4, consecutive lost arbitrations after which dispatch is forced to win (≥1)
- `CNT_WIDTH`, 16, width of transfer counter
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  drop held output entry and clear starvation state
- `disp_valid`  in  1  dispatch request valid
- `disp_ready`  out  1  dispatch request accepted this cycle
- `disp_block_id`  in  BLOCK_ID_WIDTH  dispatch block id
- `disp_block`  in  BLOCK_SIZE×INSTR_WIDTH  dispatch block (packed, index 0 = first instr)
- `cmt_valid` / `cmt_ready` / `cmt_block_id` / `cmt_block`  same as dispatch, commit side
- `out_valid`  out  1  registered block valid toward bypass path
- `out_ready`  in  1  bypass path consumes block
- `out_block_id`  out  BLOCK_ID_WIDTH  registered block id
- `out_block`  out  BLOCK_SIZE×INSTR_WIDTH  registered block
- `out_from_dispatch`, `out_from_commit`  out  1 each  source tag, one-hot when `out_valid`
- `xfer_count`  out  CNT_WIDTH  saturating count of blocks delivered (`out_valid && out_ready`)

## Operation
- `load_en = !flush && (!out_valid || out_ready)`.
- Grant selection, combinational:
  - If `starve == MAX_STARVE` and `disp_valid`, dispatch wins.
  - Otherwise, if `cmt_valid`, commit wins.
  - Otherwise, if `disp_valid`, dispatch wins.
- `disp_ready = load_en && grant_disp`; `cmt_ready = load_en && grant_cmt`. At most one ready is high per cycle.
- On acceptance, the output register loads the winner's id and block, sets its tag to 1 and the other tag to 0, and sets `out_valid = 1`.
- If `out_valid && out_ready` and nothing is accepted, clear `out_valid`. Data and tags hold their last values.
- Starvation counter `starve`, width `$clog2(MAX_STARVE+1)`:
  - Increments when `disp_valid && cmt_ready`.
  - Clears to 0 on `disp_ready` or `flush`.
  - Saturates at `MAX_STARVE`.
  - Holds otherwise, including cycles where `load_en = 0`.
- `xfer_count` increments on each `out_valid && out_ready` and saturates at all ones. It is not cleared by `flush`.
- `flush`:
  - Next cycle `out_valid = 0`.
  - Both readys are 0 in the flush cycle.
  - A transfer completing in the flush cycle (`out_valid && out_ready`) still counts.
- Requesters must hold valid/id/block stable until ready. The arbiter does not check this.

## Timing
- Reset values, one cycle after `rst` high at an edge:
  - `out_valid`, `out_from_dispatch`, `out_from_commit` = 0
  - `out_block_id` = 0, `out_block` = 0
  - `starve` = 0, `xfer_count` = 0
- During `rst`, both readys are 0. Reset mid-operation discards the held entry with no delivery.
- Latency: a request accepted at edge N is presented on `out_*` after edge N, valid in cycle N+1.
- Throughput: one block per cycle when `out_ready` is held high. There is no bubble on back-to-back transfers.
- Backpressure: while `out_valid && !out_ready`, the output is held stable and both readys are 0.
- Simultaneous drain and load in the same cycle: new entry replaces old, `out_valid` stays 1, and `xfer_count` increments.
- With `MAX_STARVE = 4` and both requesters continuously valid, the grant pattern is C,C,C,C,D repeating. Dispatch wait is bounded by `MAX_STARVE+1` accepted cycles.

## Test plan
- Reset then idle: after `rst`, all outputs 0; with `disp_valid = cmt_valid = 0` for 10 cycles, `out_valid` stays 0 and `xfer_count` = 0.
- Single dispatch: `disp_valid = 1`, id `0x2A`, block `{0x13,0x33,0x93,0x6F}`, `out_ready = 1` → `disp_ready` in cycle 0; cycle 1 `out_valid = 1`, `out_block_id = 0x2A`, `out_from_dispatch = 1`, `out_from_commit = 0`; `xfer_count = 1` after cycle 1.
- Both valid, `out_ready = 1`, `MAX_STARVE = 4`, 10 cycles → grants C,C,C,C,D,C,C,C,C,D; `starve` reads 4 at each D grant; `xfer_count = 9` after cycle 9 (10 at cycle 10).
- Backpressure: commit accepted with id `0x05`, then `out_ready = 0` for 3 cycles with `disp_valid = 1` → output holds `0x05` tagged commit, `disp_ready = 0` and `starve` unchanged throughout; on `out_ready = 1`, dispatch is accepted that cycle and delivered next.
- Flush mid-hold: `out_valid = 1`, `out_ready = 0`, `starve = 3`, then `flush` for one cycle → next cycle `out_valid = 0`, `starve = 0`, no ready asserted in the flush cycle, `xfer_count` unchanged.
- Counter saturation, `CNT_WIDTH = 4`: 20 consecutive commit transfers → `xfer_count` stops at 15; a synchronous `rst` clears it to 0 the following cycle.
